// File: rtl/serial_paralelo_if.sv
// Serial receive link: one serial bit in, recovered byte plus link status out.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output byte_strobe
  );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma-locked byte alignment, rebuilds 8-bit words.
// Latency: data_out updates on the edge sampling a byte's LSB; no backpressure (free-running bit stream).
module serial_paralelo #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         COMMA_COUNT = 4
) (
  input  logic           clk_32f,
  input  logic           reset,
  serial_paralelo_if.slave bus
);

  localparam int BCW = $clog2(COMMA_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    ACTIVE
  } state_t;

  state_t           state, state_nx;
  logic [6:0]       shift;
  logic [7:0]       word;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [BCW-1:0]   bc_cnt, bc_cnt_nx, bc_inc;
  logic [7:0]       data_q, data_nx;
  logic             valid_q, valid_nx;
  logic             strobe_q, strobe_nx;
  logic             boundary;
  logic             is_comma;

  // The word under test always includes the bit being sampled this edge.
  assign word     = {shift, bus.data_in};
  assign is_comma = (word == COMMA);
  assign boundary = (bit_cnt == 3'd7);
  assign bc_inc   = bc_cnt + BCW'(1);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state    <= HUNT;
      shift    <= '0;
      bit_cnt  <= '0;
      bc_cnt   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nx;
      shift    <= word[6:0];
      bit_cnt  <= bit_cnt_nx;
      bc_cnt   <= bc_cnt_nx;
      data_q   <= data_nx;
      valid_q  <= valid_nx;
      strobe_q <= strobe_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt + 3'd1;
    bc_cnt_nx  = bc_cnt;
    data_nx    = data_q;
    valid_nx   = valid_q;
    strobe_nx  = 1'b0;

    unique case (state)
      HUNT: begin
        // Slide bit by bit; a comma fixes the byte phase with the next bit as MSB.
        bit_cnt_nx = '0;
        if (is_comma) begin
          strobe_nx = 1'b1;
          bc_cnt_nx = BCW'(1);
          state_nx  = (COMMA_COUNT <= 1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        if (boundary) begin
          strobe_nx = 1'b1;
          if (is_comma) begin
            bc_cnt_nx = bc_inc;
            if (bc_inc == BCW'(COMMA_COUNT)) begin
              state_nx = ACTIVE;
            end
          end else begin
            // Lock was on a false comma image; resume hunting from the current bits.
            state_nx   = HUNT;
            bc_cnt_nx  = '0;
            bit_cnt_nx = '0;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          strobe_nx = 1'b1;
          if (is_comma) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = word;
            valid_nx = 1'b1;
          end
        end
      end

      default: begin
        state_nx   = HUNT;
        bit_cnt_nx = '0;
        bc_cnt_nx  = '0;
      end
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.active      = (state == ACTIVE);
  assign bus.byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed and randomized bench for serial_paralelo with a bit-history reference model.
module tb_serial_paralelo;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         CC    = 4;

  logic clk_32f = 1'b0;
  logic reset;

  serial_paralelo_if bus();

  serial_paralelo #(
    .COMMA       (COMMA),
    .COMMA_COUNT (CC)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int checks = 0;
  int errors = 0;

  // Reference model: full bit history since reset plus the sample index of the lock.
  bit         hist[$];
  bit         m_locked;
  int         m_lock_k;
  int         m_commas;
  bit         m_active;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_strobe;

  // Loopback scoreboard of data bytes the transmitter sent while the link was up.
  logic [7:0] sb[$];
  bit         sb_on = 1'b0;

  function automatic void model_edge(input logic b, input logic rst_n);
    int         k;
    logic [7:0] w;
    if (!rst_n) begin
      hist.delete();
      m_locked = 1'b0;
      m_lock_k = 0;
      m_commas = 0;
      m_active = 1'b0;
      m_data   = 8'h00;
      m_valid  = 1'b0;
      m_strobe = 1'b0;
      return;
    end
    hist.push_back(b);
    k = hist.size();
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (k - 1 - i >= 0) w[i] = hist[k - 1 - i];
    end
    m_strobe = 1'b0;
    if (!m_locked) begin
      if (w == COMMA) begin
        m_locked = 1'b1;
        m_lock_k = k;
        m_commas = 1;
        m_strobe = 1'b1;
        if (m_commas >= CC) m_active = 1'b1;
      end
    end else if ((k - m_lock_k) % 8 == 0) begin
      m_strobe = 1'b1;
      if (m_active) begin
        if (w != COMMA) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else if (w == COMMA) begin
        m_commas++;
        if (m_commas >= CC) m_active = 1'b1;
      end else begin
        m_locked = 1'b0;
        m_commas = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic rst_n);
    reset       = rst_n;
    bus.data_in = b;
    @(posedge clk_32f);
    model_edge(b, rst_n);
    #1;
    chk("data_out",    32'(bus.data_out),    32'(m_data));
    chk("valid_out",   32'(bus.valid_out),   32'(m_valid));
    chk("active",      32'(bus.active),      32'(m_active));
    chk("byte_strobe", 32'(bus.byte_strobe), 32'(m_strobe));
    if (sb_on && bus.byte_strobe && bus.valid_out) begin
      if (sb.size() == 0) begin
        chk("loopback_extra", 32'(bus.data_out), 32'hFFFF_FFFF);
      end else begin
        chk("loopback", 32'(bus.data_out), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int         sel;
    int         nb;

    reset       = 1'b0;
    bus.data_in = 1'b0;

    // T1: held in reset with toggling data
    for (int i = 0; i < 4; i++) step(i[0], 1'b0);
    chk("t1_data", 32'(bus.data_out), 32'h00);

    // T2: junk bits then four commas
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    chk("t2_not_yet_active", 32'(bus.active), 32'd0);
    send_byte(COMMA);
    chk("t2_active", 32'(bus.active), 32'd1);
    chk("t2_valid", 32'(bus.valid_out), 32'd0);

    // T3: two data bytes
    send_byte(8'h12);
    chk("t3_data12", 32'(bus.data_out), 32'h12);
    chk("t3_valid12", 32'(bus.valid_out), 32'd1);
    send_byte(8'h34);
    chk("t3_data34", 32'(bus.data_out), 32'h34);

    // T4: idle comma after data
    send_byte(COMMA);
    chk("t4_valid", 32'(bus.valid_out), 32'd0);
    chk("t4_hold", 32'(bus.data_out), 32'h34);
    chk("t4_active", 32'(bus.active), 32'd1);

    // T5: interrupted comma run falls back to hunting
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'h55);
    chk("t5_after55", 32'(bus.active), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    chk("t5_three_bc", 32'(bus.active), 32'd0);
    send_byte(COMMA);
    chk("t5_active", 32'(bus.active), 32'd1);

    // T6: reset mid-byte while active, relock, then random loopback traffic
    send_byte(8'hA5);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("t6_reset_active", 32'(bus.active), 32'd0);
    chk("t6_reset_data", 32'(bus.data_out), 32'h00);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    chk("t6_relock", 32'(bus.active), 32'd1);
    sb_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rb = COMMA;
      end else begin
        rb = 8'($urandom_range(0, 255));
      end
      if (rb != COMMA) sb.push_back(rb);
      send_byte(rb);
    end
    sb_on = 1'b0;
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    // T7: random bit slips, junk and commas from reset
    step(1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1) begin
        send_byte(COMMA);
      end else if (sel == 2) begin
        send_byte(8'($urandom_range(0, 255)));
      end else begin
        nb = $urandom_range(1, 7);
        for (int j = 0; j < nb; j++) step(1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
